// File: rtl/gs_pkg.sv
// Shared types for the execute-to-memory stage: memory-op encodings,
// skid-buffer states and the payload carried downstream.
package gs_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    B = 2'd0,
    H = 2'd1,
    W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [31:0] alu_data;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic        rd_we;
    mem_op_e     mem_op;
    mem_size_e   mem_size;
    logic [31:0] store_data;
  } ex_pkt_t;

endpackage

// File: rtl/gs_skid_buf.sv
// Two-entry skid buffer with a registered in_ready; out_data always shows
// the oldest (main) entry, the skid entry backs it up under stall.
module gs_skid_buf
  import gs_pkg::*;
#(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  skid_state_e state, state_nxt;
  T            main_q, skid_q;
  logic        ready_q;
  logic        in_xfer, out_xfer;

  assign in_xfer  = in_valid && ready_q;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != TWO);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_xfer) state_nxt = ONE;
      ONE: begin
        if (in_xfer && !out_xfer)      state_nxt = TWO;
        else if (!in_xfer && out_xfer) state_nxt = EMPTY;
      end
      TWO:     if (out_xfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state != EMPTY);
    out_data  = main_q;
    in_ready  = ready_q;
  end

  // Draining from TWO promotes skid into main on the same edge to keep FIFO order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: if (in_xfer) main_q <= in_data;
        ONE: begin
          if (in_xfer && out_xfer) main_q <= in_data;
          else if (in_xfer)        skid_q <= in_data;
        end
        TWO:     if (out_xfer) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gs_ex_mem_stage.sv
// Execute-to-memory pipeline stage: buffers ALU results toward memory and
// raises a one-cycle redirect or misalignment trap for taken control flow.
module gs_ex_mem_stage
  import gs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_data,
  input  logic        ex_br_flag,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_br_target,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_we,
  input  logic [1:0]  ex_mem_op,
  input  logic [1:0]  ex_mem_size,
  input  logic [31:0] ex_store_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output ex_pkt_t     mem_pkt,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        misalign_trap
);

  ex_pkt_t pkt;
  logic    flush, taken, misaligned, accept, buf_in_valid;

  // Beats arriving during the redirect/trap cycle are wrong-path: consumed, never stored.
  assign flush        = redirect_valid || misalign_trap;
  assign buf_in_valid = ex_valid && !flush;
  assign accept       = ex_valid && ex_ready && !flush;

  always_comb begin
    taken          = ex_is_jump || (ex_is_branch && ex_br_flag);
    misaligned     = (ex_br_target[1:0] != 2'b00);
    pkt.alu_data   = ex_is_jump ? ex_pc + 32'd4 : ex_alu_data;
    pkt.pc         = ex_pc;
    pkt.rd_addr    = ex_rd_addr;
    pkt.rd_we      = ex_rd_we && !ex_is_branch && !(taken && misaligned);
    pkt.mem_op     = ex_is_branch ? NONE : mem_op_e'(ex_mem_op);
    pkt.mem_size   = mem_size_e'(ex_mem_size);
    pkt.store_data = ex_store_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      misalign_trap  <= 1'b0;
    end else begin
      redirect_valid <= accept && taken && !misaligned;
      misalign_trap  <= accept && taken && misaligned;
      if (accept && taken && !misaligned) redirect_pc <= ex_br_target;
    end
  end

  gs_skid_buf #(
    .T(ex_pkt_t)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (buf_in_valid),
    .in_ready (ex_ready),
    .in_data  (pkt),
    .out_valid(mem_valid),
    .out_ready(mem_ready),
    .out_data (mem_pkt)
  );

endmodule

// File: tb/tb_gs_ex_mem_stage.sv
// Directed bench for gs_ex_mem_stage: single-beat vector table plus scripted
// stall, wrong-path and reset sequences.
module tb_gs_ex_mem_stage;
  import gs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_data, ex_br_target, ex_pc, ex_store_data;
  logic        ex_br_flag, ex_is_branch, ex_is_jump, ex_rd_we;
  logic [4:0]  ex_rd_addr;
  logic [1:0]  ex_mem_op, ex_mem_size;
  logic        mem_valid, mem_ready;
  ex_pkt_t     mem_pkt;
  logic        redirect_valid, misalign_trap;
  logic [31:0] redirect_pc;

  int unsigned n_pass = 0, n_total = 0;

  gs_ex_mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_data(ex_alu_data), .ex_br_flag(ex_br_flag), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_br_target(ex_br_target), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_mem_op(ex_mem_op),
    .ex_mem_size(ex_mem_size), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pkt(mem_pkt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        br, j, flag;
    logic [31:0] alu, pc, tgt;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  op, size;
    logic [31:0] sd;
    logic [31:0] e_alu;
    logic        e_we;
    logic [1:0]  e_op;
    logic        e_redir, e_trap;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] got[$];
  logic        acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_beat(input logic br, input logic j, input logic flag,
                          input logic [31:0] alu, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic [4:0] rd,
                          input logic we, input logic [1:0] op,
                          input logic [1:0] size, input logic [31:0] sd);
    ex_is_branch = br; ex_is_jump = j; ex_br_flag = flag;
    ex_alu_data = alu; ex_pc = pc; ex_br_target = tgt;
    ex_rd_addr = rd; ex_rd_we = we; ex_mem_op = op; ex_mem_size = size;
    ex_store_data = sd;
  endtask

  task automatic set_add(input logic [31:0] alu);
    set_beat(1'b0, 1'b0, 1'b0, alu, 32'h1000, 32'h0, 5'd3, 1'b1, 2'd0, 2'd2, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          name      br   j    flg  alu           pc            tgt           rd    we   op    sz    sd        e_alu         e_we e_op  rdr  trp  e_rpc
    vecs[0] = '{"add",    1'b0,1'b0,1'b0,32'h0000_0010,32'h0000_1000,32'h0,       5'd5, 1'b1,2'd0,2'd2,32'h0,    32'h0000_0010,1'b1,2'd0,1'b0,1'b0,32'h0};
    vecs[1] = '{"load",   1'b0,1'b0,1'b0,32'h0000_2000,32'h0000_1004,32'h0,       5'd7, 1'b1,2'd1,2'd2,32'h0,    32'h0000_2000,1'b1,2'd1,1'b0,1'b0,32'h0};
    vecs[2] = '{"store",  1'b0,1'b0,1'b0,32'h0000_3004,32'h0000_1008,32'h0,       5'd0, 1'b0,2'd2,2'd0,32'hAB,   32'h0000_3004,1'b0,2'd2,1'b0,1'b0,32'h0};
    vecs[3] = '{"beq_tk", 1'b1,1'b0,1'b1,32'h0000_0001,32'h0000_100C,32'h0000_0100,5'd4, 1'b1,2'd1,2'd2,32'h0,    32'h0000_0001,1'b0,2'd0,1'b1,1'b0,32'h0000_0100};
    vecs[4] = '{"bne_nt", 1'b1,1'b0,1'b0,32'h0000_0002,32'h0000_1010,32'h0000_0300,5'd4, 1'b1,2'd2,2'd2,32'h0,    32'h0000_0002,1'b0,2'd0,1'b0,1'b0,32'h0};
    vecs[5] = '{"jal_wr", 1'b0,1'b1,1'b0,32'h0000_0099,32'hFFFF_FFFC,32'h0000_0200,5'd1, 1'b1,2'd0,2'd2,32'h0,    32'h0000_0000,1'b1,2'd0,1'b1,1'b0,32'h0000_0200};
    vecs[6] = '{"jal_mis",1'b0,1'b1,1'b0,32'h0000_0099,32'h0000_0040,32'h0000_0102,5'd1, 1'b1,2'd0,2'd2,32'h0,    32'h0000_0044,1'b0,2'd0,1'b0,1'b1,32'h0};
    vecs[7] = '{"br_mis", 1'b1,1'b0,1'b1,32'h0000_0005,32'h0000_0050,32'h0000_01FE,5'd2, 1'b1,2'd0,2'd2,32'h0,    32'h0000_0005,1'b0,2'd0,1'b0,1'b1,32'h0};

    rst = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    set_add(32'h0);
    #1;
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_ex_ready", 32'(ex_ready), 32'd0);
    check("rst_redir", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check("rst_trap", 32'(misalign_trap), 32'd0);
    check("rst_pkt_alu", mem_pkt.alu_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1 check("ready_before_edge", 32'(ex_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(ex_ready), 32'd1);

    // Single-beat vectors with mem_ready held high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_beat(vecs[i].br, vecs[i].j, vecs[i].flag, vecs[i].alu, vecs[i].pc, vecs[i].tgt,
               vecs[i].rd, vecs[i].we, vecs[i].op, vecs[i].size, vecs[i].sd);
      ex_valid = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0;
      check({vecs[i].name, "_valid"}, 32'(mem_valid), 32'd1);
      check({vecs[i].name, "_alu"}, mem_pkt.alu_data, vecs[i].e_alu);
      check({vecs[i].name, "_we"}, 32'(mem_pkt.rd_we), 32'(vecs[i].e_we));
      check({vecs[i].name, "_op"}, 32'(mem_pkt.mem_op), 32'(vecs[i].e_op));
      check({vecs[i].name, "_redir"}, 32'(redirect_valid), 32'(vecs[i].e_redir));
      check({vecs[i].name, "_trap"}, 32'(misalign_trap), 32'(vecs[i].e_trap));
      if (vecs[i].e_redir) check({vecs[i].name, "_rpc"}, redirect_pc, vecs[i].e_rpc);
      @(negedge clk);
      check({vecs[i].name, "_drained"}, 32'(mem_valid), 32'd0);
      check({vecs[i].name, "_redir_end"}, 32'(redirect_valid), 32'd0);
      check({vecs[i].name, "_trap_end"}, 32'(misalign_trap), 32'd0);
    end

    // Stall: A and B fill the buffer, C waits, then all drain in order.
    mem_ready = 1'b0;
    @(negedge clk); set_add(32'hA); ex_valid = 1'b1;
    @(negedge clk);
    check("stall_ready_one", 32'(ex_ready), 32'd1);
    check("stall_valid_a", 32'(mem_valid), 32'd1);
    set_add(32'hB);
    @(negedge clk);
    check("stall_ready_two", 32'(ex_ready), 32'd0);
    check("stall_head_a", mem_pkt.alu_data, 32'hA);
    set_add(32'hC);
    @(negedge clk);
    check("stall_ready_held", 32'(ex_ready), 32'd0);
    check("stall_head_stable", mem_pkt.alu_data, 32'hA);
    mem_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      acc = ex_valid && ex_ready;
      if (mem_valid && mem_ready) got.push_back(mem_pkt.alu_data);
      @(negedge clk);
      if (acc) ex_valid = 1'b0;
    end
    check("order_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("order_0", got[0], 32'hA);
      check("order_1", got[1], 32'hB);
      check("order_2", got[2], 32'hC);
    end

    // Wrong-path beat during the redirect cycle, then a normal beat right after.
    @(negedge clk);
    set_beat(1'b1, 1'b0, 1'b1, 32'hB0, 32'h2000, 32'h100, 5'd0, 1'b0, 2'd0, 2'd2, 32'h0);
    ex_valid = 1'b1;
    @(negedge clk);
    check("wp_redir", 32'(redirect_valid), 32'd1);
    check("wp_rpc", redirect_pc, 32'h100);
    check("wp_ready", 32'(ex_ready), 32'd1);
    set_add(32'hDEAD);
    @(negedge clk);
    check("wp_redir_end", 32'(redirect_valid), 32'd0);
    check("wp_discarded", 32'(mem_valid), 32'd0);
    set_add(32'h77);
    @(negedge clk);
    ex_valid = 1'b0;
    check("after_pulse_valid", 32'(mem_valid), 32'd1);
    check("after_pulse_alu", mem_pkt.alu_data, 32'h77);
    check("after_pulse_redir", 32'(redirect_valid), 32'd0);
    @(negedge clk);

    // Reset while full with a redirect pending.
    mem_ready = 1'b0;
    set_add(32'h55); ex_valid = 1'b1;
    @(negedge clk);
    set_beat(1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h200, 5'd1, 1'b1, 2'd0, 2'd2, 32'h0);
    @(negedge clk);
    ex_valid = 1'b0;
    check("pre_rst_redir", 32'(redirect_valid), 32'd1);
    check("pre_rst_full", 32'(ex_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_mem_valid", 32'(mem_valid), 32'd0);
    check("arst_ex_ready", 32'(ex_ready), 32'd0);
    check("arst_redir", 32'(redirect_valid), 32'd0);
    check("arst_rpc", redirect_pc, 32'd0);
    check("arst_trap", 32'(misalign_trap), 32'd0);
    check("arst_pkt_alu", mem_pkt.alu_data, 32'd0);
    check("arst_pkt_pc", mem_pkt.pc, 32'd0);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(ex_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("rel_no_stale", 32'(mem_valid), 32'd0);
      check("rel_no_redir", 32'(redirect_valid), 32'd0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gs_ex_mem_stage.md
GS_EX_MEM_STAGE -- requirements
Module: gs_ex_mem_stage

Interface
REQ-001 Ports SHALL be, in order:
- clk  in  1  -- sole clock, rising edge.
- rst  in  1  -- asynchronous, active-low reset.
REQ-002 Upstream ports (from ALU / execute) SHALL be:
- ex_valid  in  1  -- beat valid.
- ex_ready  out  1  -- stage can accept.
- ex_alu_data  in  32  -- ALU result.
- ex_br_flag  in  1  -- ALU branch-condition result.
- ex_is_branch  in  1  -- conditional branch.
- ex_is_jump  in  1  -- unconditional jump.
- ex_br_target  in  32  -- branch/jump target.
- ex_pc  in  32  -- instruction PC.
- ex_rd_addr  in  5  -- destination register.
- ex_rd_we  in  1  -- register write enable.
- ex_mem_op  in  2  -- NONE/LOAD/STORE.
- ex_mem_size  in  2  -- B/H/W.
- ex_store_data  in  32  -- store operand.
REQ-003 Downstream ports SHALL be:
- mem_valid  out  1.
- mem_ready  in  1.
- mem_pkt  out  ex_pkt_t -- alu_data, pc, rd_addr, rd_we, mem_op, mem_size, store_data.
REQ-004 Redirect ports SHALL be:
- redirect_valid  out  1  -- one-cycle pulse.
- redirect_pc  out  32  -- new fetch PC.
- misalign_trap  out  1  -- one-cycle pulse.

Function
REQ-005 Upstream transfer SHALL occur when ex_valid && ex_ready; downstream transfer SHALL occur when mem_valid && mem_ready.
REQ-006 Buffering SHALL be a 2-entry skid (main, skid) with states EMPTY, ONE, TWO.
REQ-007 ex_ready SHALL be a registered signal equal to (state != TWO), with no combinational path from mem_ready.
REQ-008 State transitions SHALL be:
- EMPTY -> ONE on an upstream transfer.
- ONE -> TWO on an upstream transfer without a downstream transfer.
- ONE -> EMPTY on a downstream transfer without an upstream transfer.
- ONE stays ONE on a simultaneous upstream and downstream transfer.
- TWO -> ONE on a downstream transfer; an upstream transfer is impossible in TWO.
REQ-009 Ordering SHALL be strict FIFO. mem_pkt SHALL always present the main entry, and a downstream transfer in TWO SHALL move skid into main in the same edge.
REQ-010 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL appear on mem_valid after edge N when the stage was EMPTY or became empty at edge N.
REQ-011 mem_valid and mem_pkt SHALL hold stable while mem_valid && !mem_ready.
REQ-012 Taken SHALL be defined as ex_is_jump || (ex_is_branch && ex_br_flag), evaluated at the upstream transfer.
REQ-013 A taken beat with ex_br_target[1:0]==0 SHALL assert redirect_valid for exactly the next cycle, with redirect_pc = ex_br_target.
REQ-014 A taken beat with ex_br_target[1:0]!=0 SHALL assert misalign_trap for one cycle instead, with no redirect_valid; the beat SHALL still be forwarded with rd_we forced to 0.
REQ-015 A taken jump SHALL forward alu_data = ex_pc + 4, wrapping modulo 2^32; a conditional branch SHALL forward rd_we=0 and mem_op=NONE.
REQ-016 During a redirect_valid or misalign_trap cycle the stage SHALL accept (ex_ready=1 when not TWO) and discard any upstream beat as wrong-path; no state change or redirect SHALL result from it.
REQ-017 A redirect/trap on consecutive accepted beats SHALL be impossible by REQ-016; a beat arriving the cycle after the pulse SHALL be processed normally.
REQ-018 Redirect generation SHALL be independent of mem_ready, so downstream stall SHALL NOT delay redirect_valid.

Reset
REQ-019 On rst low, asynchronously:
- state=EMPTY, mem_valid=0, ex_ready=0.
- redirect_valid=0, redirect_pc=0, misalign_trap=0.
- mem_pkt fields=0.
REQ-020 ex_ready SHALL rise on the first clk edge after rst deasserts.
REQ-021 Reset mid-operation SHALL drop all buffered beats and any pending redirect.

Structure
REQ-022 gs_pkg SHALL hold:
- ex_pkt_t struct.
- mem_op_e {NONE, LOAD, STORE}.
- mem_size_e {B, H, W}.
- skid_state_e {EMPTY, ONE, TWO}.
REQ-023 Buffering SHALL be the sub-module gs_skid_buf, parameterised on payload type; redirect logic SHALL be in gs_ex_mem_stage.

Verification
REQ-024 ADD result 0x0000_0010 with mem_ready=1:
- mem_valid high one cycle after acceptance.
- mem_pkt.alu_data=0x10.
- no redirect_valid.
REQ-025 mem_ready=0, three beats A,B,C offered:
- A, B accepted; ex_ready=0 after B; C held.
- Raising mem_ready delivers A, B, C in order with no loss or duplication.
REQ-026 BEQ beat, br_flag=1, target 0x0000_0100:
- redirect_valid for exactly 1 cycle, redirect_pc=0x100.
- A beat presented in that cycle is consumed and never appears on mem_valid.
REQ-027 JAL at pc 0xFFFF_FFFC, target 0x200:
- mem_pkt.alu_data=0x0000_0000 (wrap).
- redirect_pc=0x200.
REQ-028 Jump target 0x0000_0102:
- misalign_trap pulse, no redirect_valid.
- Forwarded beat has rd_we=0.
REQ-029 rst asserted low while in state TWO with a redirect pending:
- All outputs reach 0 immediately, without a clock edge.
- No stale beat appears after release.
